// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and
// the op encoding carried from request capture to the memory port.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } arb_state_t;

    localparam logic MEM_OP_READ  = 1'b0;
    localparam logic MEM_OP_WRITE = 1'b1;

endpackage

// File: rtl/arb_req_latch.sv
// Per-port capture of a one-cycle read/write strobe into a pending flag and
// op bit, flagging malformed or overlapping strobes.
module arb_req_latch
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic read_i,
    input  logic write_i,
    input  logic busy_i,
    input  logic clr_i,
    output logic pend_o,
    output logic op_o,
    output logic err_o
);

    logic pend_q, pend_d;
    logic op_q, op_d;

    // NOTE: defaults first so every path assigns every output; no latches.
    always_comb begin
        pend_d = pend_q;
        op_d   = op_q;
        err_o  = 1'b0;
        if (clr_i) begin
            pend_d = 1'b0;
        end
        if (read_i || write_i) begin
            if (pend_q || busy_i) begin
                err_o = 1'b1;
            end else begin
                pend_d = 1'b1;
                op_d   = write_i ? MEM_OP_WRITE : MEM_OP_READ;
                err_o  = read_i && write_i;
            end
        end
    end

    // NOTE: sequential state uses <= so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
            op_q   <= MEM_OP_READ;
        end else begin
            pend_q <= pend_d;
            op_q   <= op_d;
        end
    end

    assign pend_o = pend_q;
    assign op_o   = op_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one level-held memory port between the CPU
// (port 0) and the debug loader (port 1), with registered read return and timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_read,
    input  logic              p0_write,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_resp,
    input  logic              p1_read,
    input  logic              p1_write,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic              err
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit               TMO_EN   = (TIMEOUT != 0);

    arb_state_t        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q;

    logic pend0, pend1, op0, op1, lerr0, lerr1, clr0, clr1, tmo_err, sel;
    logic busy0, busy1;

    assign busy0 = (state_q != IDLE) && !gnt_q;
    assign busy1 = (state_q != IDLE) &&  gnt_q;

    arb_req_latch u_lat0 (
        .clk(clk), .rst(rst), .read_i(p0_read), .write_i(p0_write), .busy_i(busy0),
        .clr_i(clr0), .pend_o(pend0), .op_o(op0), .err_o(lerr0)
    );

    arb_req_latch u_lat1 (
        .clk(clk), .rst(rst), .read_i(p1_read), .write_i(p1_write), .busy_i(busy1),
        .clr_i(clr1), .pend_o(pend1), .op_o(op1), .err_o(lerr1)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        cnt_d    = cnt_q;
        clr0     = 1'b0;
        clr1     = 1'b0;
        tmo_err  = 1'b0;
        // On a tie the port that was not served last wins.
        sel      = (pend0 && pend1) ? !last_q : pend1;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pend0 || pend1) begin
                    gnt_d   = sel;
                    last_d  = sel;
                    op_d    = sel ? op1 : op0;
                    addr_d  = sel ? p1_addr : p0_addr;
                    wdata_d = sel ? p1_wdata : p0_wdata;
                    clr0    = !sel;
                    clr1    = sel;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (mem_resp) begin
                    if (op_q == MEM_OP_READ) begin
                        if (gnt_q) rdata1_d = mem_rdata;
                        else       rdata0_d = mem_rdata;
                    end
                    state_d = DONE;
                end else if (TMO_EN && cnt_q == TMO_LAST) begin
                    tmo_err = 1'b1;
                    if (op_q == MEM_OP_READ) begin
                        if (gnt_q) rdata1_d = '0;
                        else       rdata0_d = '0;
                    end
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            op_q     <= MEM_OP_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            cnt_q    <= cnt_d;
            err_q    <= err_q | lerr0 | lerr1 | tmo_err;
        end
    end

    assign mem_read  = (state_q == ISSUE) && (op_q == MEM_OP_READ);
    assign mem_write = (state_q == ISSUE) && (op_q == MEM_OP_WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign p0_resp   = (state_q == DONE) && !gnt_q;
    assign p1_resp   = (state_q == DONE) &&  gnt_q;
    assign p0_rdata  = rdata0_q;
    assign p1_rdata  = rdata1_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural memory with programmable
// latency answers requests; the main sequence drives strobes and checks results.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_read = 1'b0, p0_write = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic [DW-1:0] p0_rdata;
    logic          p0_resp;
    logic          p1_read = 1'b0, p1_write = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;
    logic [DW-1:0] p1_rdata;
    logic          p1_resp;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_resp;
    logic          err;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Memory model controls and log
    bit            mem_en  = 1'b1;
    int            mem_lat = 3;
    int            mem_cnt = 0;
    int            txn_count = 0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [DW-1:0] last_wr_data = '0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .p0_read(p0_read), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_resp(p0_resp),
        .p1_read(p1_read), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_resp(p1_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    initial begin
        mem_resp  = 1'b0;
        mem_rdata = 32'hBAD0BAD0;
        forever begin
            @(negedge clk);
            if (mem_en && !rst && (mem_read || mem_write) && !mem_resp) begin
                mem_cnt++;
                if (mem_cnt >= mem_lat) begin
                    mem_resp  = 1'b1;
                    mem_rdata = mem_model(mem_addr);
                    txn_count++;
                    if (mem_write) begin
                        last_wr_addr = mem_addr;
                        last_wr_data = mem_wdata;
                    end
                end
            end else begin
                mem_resp  = 1'b0;
                mem_rdata = 32'hBAD0BAD0;
                mem_cnt   = 0;
            end
        end
    end

    task automatic strobe(input bit r0, input bit w0, input bit r1, input bit w1);
        @(negedge clk);
        p0_read = r0; p0_write = w0; p1_read = r1; p1_write = w1;
        @(negedge clk);
        p0_read = 1'b0; p0_write = 1'b0; p1_read = 1'b0; p1_write = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        p0_read = 1'b0; p0_write = 1'b0; p1_read = 1'b0; p1_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_any_resp(output int who, output int n, output int rd, output int wr,
                                 output logic [AW-1:0] addr);
        who = -1; n = 0; rd = 0; wr = 0; addr = '0;
        for (int i = 0; i < 100 && who < 0; i++) begin
            @(negedge clk);
            n++;
            if (mem_read)  rd++;
            if (mem_write) wr++;
            if (mem_read || mem_write) addr = mem_addr;
            if (p0_resp)      who = 0;
            else if (p1_resp) who = 1;
        end
        check("resp_seen", who >= 0, 1);
    endtask

    initial begin
        int who, n, rd, wr, t0, quiet;
        logic [AW-1:0] a;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_resp", {p0_resp, p1_resp}, 0);
        check("rst_rdata", {p0_rdata, p1_rdata}, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        // Uncontended read with 3-cycle memory
        mem_lat = 3;
        p0_addr = 32'h100;
        strobe(1, 0, 0, 0);
        wait_any_resp(who, n, rd, wr, a);
        check("t1_who", who, 0);
        check("t1_latency", n, 4);
        check("t1_rd_cycles", rd, 3);
        check("t1_addr", a, 32'h100);
        check("t1_rdata", p0_rdata, 32'hDEADBEEF);
        @(negedge clk);
        check("t1_resp_pulse", p0_resp, 0);
        check("t1_err", err, 0);

        // Tie after reset: port 0 first, then port 1 write
        do_reset();
        mem_lat  = 2;
        p0_addr  = 32'h104;
        p1_addr  = 32'h200;
        p1_wdata = 32'h55;
        strobe(1, 0, 0, 1);
        wait_any_resp(who, n, rd, wr, a);
        check("t2_first", who, 0);
        check("t2_p0_rdata", p0_rdata, mem_model(32'h104));
        wait_any_resp(who, n, rd, wr, a);
        check("t2_second", who, 1);
        check("t2_gap", n, 4);
        check("t2_wr_cycles", wr, 2);
        check("t2_wr_addr", last_wr_addr, 32'h200);
        check("t2_wr_data", last_wr_data, 32'h55);
        check("t2_p1_rdata", p1_rdata, 0);
        check("t2_p0_rdata_hold", p0_rdata, mem_model(32'h104));
        strobe(1, 0, 0, 1);
        wait_any_resp(who, n, rd, wr, a);
        check("t2_repeat_first", who, 0);
        wait_any_resp(who, n, rd, wr, a);
        check("t2_repeat_second", who, 1);
        check("t2_err", err, 0);

        // Continuous contention: strict alternation
        do_reset();
        p0_addr = 32'h108;
        p1_addr = 32'h204;
        strobe(1, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            wait_any_resp(who, n, rd, wr, a);
            check($sformatf("t3_grant%0d", i), who, i % 2);
            if (who == 0) strobe(1, 0, 0, 0);
            else if (who == 1) strobe(0, 0, 1, 0);
        end
        check("t3_err", err, 0);

        // Timeout on port 1 read after a good read
        do_reset();
        p1_addr = 32'h208;
        strobe(0, 0, 1, 0);
        wait_any_resp(who, n, rd, wr, a);
        check("t4_pre_rdata", p1_rdata, mem_model(32'h208));
        check("t4_pre_err", err, 0);
        mem_en = 1'b0;
        strobe(0, 0, 1, 0);
        wait_any_resp(who, n, rd, wr, a);
        check("t4_who", who, 1);
        check("t4_rd_cycles", rd, 16);
        check("t4_rdata", p1_rdata, 0);
        check("t4_err", err, 1);
        repeat (5) @(negedge clk);
        check("t4_err_sticky", err, 1);
        mem_en = 1'b1;

        // Read+write together: write wins, err set
        do_reset();
        p0_addr  = 32'h10C;
        p0_wdata = 32'h77;
        t0 = txn_count;
        strobe(1, 1, 0, 0);
        wait_any_resp(who, n, rd, wr, a);
        check("t5_who", who, 0);
        check("t5_rd", rd, 0);
        check("t5_wr_data", last_wr_data, 32'h77);
        check("t5_txn", txn_count - t0, 1);
        check("t5_err", err, 1);

        // Second strobe while in service: ignored, err set
        do_reset();
        check("t5b_err_clear", err, 0);
        mem_lat = 6;
        t0 = txn_count;
        strobe(1, 0, 0, 0);
        strobe(0, 1, 0, 0);
        wait_any_resp(who, n, rd, wr, a);
        check("t5b_who", who, 0);
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_read || mem_write || p0_resp || p1_resp) quiet++;
        end
        check("t5b_no_second", quiet, 0);
        check("t5b_txn", txn_count - t0, 1);
        check("t5b_err", err, 1);

        // Reset during ISSUE
        do_reset();
        mem_lat = 10;
        p0_addr = 32'h110;
        strobe(1, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("t6_in_issue", mem_read, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_mem_read", mem_read, 0);
        check("t6_mem_addr", mem_addr, 0);
        check("t6_resp", {p0_resp, p1_resp}, 0);
        rst = 1'b0;
        quiet = 0;
        repeat (15) begin
            @(negedge clk);
            if (mem_read || mem_write || p0_resp || p1_resp) quiet++;
        end
        check("t6_dropped", quiet, 0);
        mem_lat = 3;
        p0_addr = 32'h114;
        strobe(1, 0, 0, 0);
        wait_any_resp(who, n, rd, wr, a);
        check("t6_after_who", who, 0);
        check("t6_after_rdata", p0_rdata, mem_model(32'h114));
        check("t6_err", err, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
